adder_sched: RTL and testbench

Round-robin scheduler that shares one `adder` instance (registered-sum variant: `x`, `y`, `cin` in; `sm_r`, `sm_zero_r` out, one cycle after the inputs are registered) between NREQ requesters. Each cycle it picks one requester, registers that requester's operands onto the adder inputs, and tracks the in-flight request ID. When the sum emerges it returns a tagged response with a signed-overflow flag. It sits between the requesting engines and the adder and is the only driver of the adder's inputs.

---
 rtl/adder_sched.sv | 106 ++++++++++
 tb/tb_adder_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sched.sv
// Round-robin scheduler sharing one registered-sum adder between NREQ requesters.
// Issues at most one operation per cycle and returns tagged responses two cycles later.
module adder_sched #(
  parameter  int NREQ = 4,
  parameter  int W    = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ-1:0]   req_cin,
  input  logic [NREQ-1:0]   req_mask,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      add_x,
  output logic [W-1:0]      add_y,
  output logic              add_cin,
  input  logic [W-1:0]      add_sm_r,
  input  logic              add_sm_zero_r,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_zero,
  output logic              rsp_ovf,
  output logic [15:0]       done_cnt
);

  logic [NREQ-1:0] elig;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  cand;
  logic            accept;
  logic [W-1:0]    sel_x;
  logic [W-1:0]    sel_y;
  logic            sel_cin;

  logic            s1_valid, s2_valid;
  logic [IDW-1:0]  s1_id, s2_id;
  logic            s1_sx, s1_sy, s2_sx, s2_sy;

  assign elig = req & req_mask;

  // Search starts just after the last winner, so the previous grantee has lowest priority.
  always_comb begin
    gnt    = '0;
    gnt_id = ptr;
    cand   = '0;
    accept = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!accept && elig[cand]) begin
        accept = 1'b1;
        gnt_id = cand;
      end
    end
    if (!rst_n) accept = 1'b0;
    if (accept) gnt[gnt_id] = 1'b1;
  end

  assign sel_x   = req_x[int'(gnt_id)*W +: W];
  assign sel_y   = req_y[int'(gnt_id)*W +: W];
  assign sel_cin = req_cin[gnt_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_x    <= '0;
      add_y    <= '0;
      add_cin  <= 1'b0;
      ptr      <= IDW'(NREQ - 1);
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_sx    <= 1'b0;
      s1_sy    <= 1'b0;
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_sx    <= 1'b0;
      s2_sy    <= 1'b0;
      done_cnt <= '0;
    end else begin
      if (accept) begin
        add_x   <= sel_x;
        add_y   <= sel_y;
        add_cin <= sel_cin;
        ptr     <= gnt_id;
        s1_id   <= gnt_id;
        s1_sx   <= sel_x[W-1];
        s1_sy   <= sel_y[W-1];
      end
      s1_valid <= accept;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_sx    <= s1_sx;
      s2_sy    <= s1_sy;
      if (s2_valid) done_cnt <= done_cnt + 16'd1;
    end
  end

  // Stage 2 lines up with the adder's registered sum.
  assign rsp_valid = s2_valid;
  assign rsp_id    = s2_id;
  assign rsp_sum   = add_sm_r;
  assign rsp_zero  = add_sm_zero_r;
  assign rsp_ovf   = s2_valid && (s2_sx == s2_sy) && (add_sm_r[W-1] != s2_sx);

endmodule

// File: tb/tb_adder_sched.sv
// Bench for adder_sched: models the shared adder, predicts grants and responses
// from the scheduling rules, and pins the model with hand-computed scenarios.
module tb_adder_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req, req_cin, req_mask, gnt;
  logic [NREQ*W-1:0] req_x, req_y;
  logic [W-1:0]     add_x, add_y, add_sm_r, rsp_sum;
  logic             add_cin, add_sm_zero_r, rsp_valid, rsp_zero, rsp_ovf;
  logic [1:0]       rsp_id;
  logic [15:0]      done_cnt;

  int nchecks = 0;
  int nerrors = 0;

  adder_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .req_y(req_y),
    .req_cin(req_cin), .req_mask(req_mask), .gnt(gnt), .add_x(add_x),
    .add_y(add_y), .add_cin(add_cin), .add_sm_r(add_sm_r),
    .add_sm_zero_r(add_sm_zero_r), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // Registered-sum adder the scheduler drives.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_sm_r      <= '0;
      add_sm_zero_r <= 1'b1;
    end else begin
      add_sm_r      <= add_x + add_y + {7'b0, add_cin};
      add_sm_zero_r <= ((add_x + add_y + {7'b0, add_cin}) == 8'd0);
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct {int due; int id; logic [7:0] sum; bit zero; bit ovf;} exp_t;
  typedef struct {int id; logic [7:0] sum; bit zero; bit ovf;} rsp_t;
  exp_t exp_q[$];
  rsp_t rsp_log[$];
  int   grant_log[$];

  int         cyc = 0;
  int         mptr = NREQ - 1;
  int         mdone = 0;
  logic [7:0] max = 0, may = 0;
  bit         mac = 0;

  always @(negedge clk) begin
    int eg, xs, ys, full;
    logic [NREQ-1:0] el;
    logic [NREQ-1:0] exp_gnt;
    bit due;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_id", 32'(rsp_id), 32'h0);
      chk("rst_rsp_ovf", 32'(rsp_ovf), 32'h0);
      chk("rst_add_x", 32'(add_x), 32'h0);
      chk("rst_add_y", 32'(add_y), 32'h0);
      chk("rst_add_cin", 32'(add_cin), 32'h0);
      chk("rst_done_cnt", 32'(done_cnt), 32'h0);
      exp_q.delete();
      mptr = NREQ - 1; mdone = 0; max = 0; may = 0; mac = 0;
    end else begin
      // Winner: lowest eligible ID above the last winner, else lowest eligible ID.
      el = req & req_mask;
      eg = -1;
      for (int i = 0; i < NREQ; i++) if (el[i] && i > mptr && eg < 0) eg = i;
      for (int i = 0; i < NREQ; i++) if (el[i] && eg < 0) eg = i;
      exp_gnt = '0;
      if (eg >= 0) exp_gnt[eg] = 1'b1;
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("add_x", 32'(add_x), 32'(max));
      chk("add_y", 32'(add_y), 32'(may));
      chk("add_cin", 32'(add_cin), 32'(mac));
      chk("done_cnt", 32'(done_cnt), 32'(mdone));
      due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("rsp_valid", 32'(rsp_valid), 32'(due));
      if (rsp_valid) rsp_log.push_back('{int'(rsp_id), rsp_sum, rsp_zero, rsp_ovf});
      if (due) begin
        e = exp_q.pop_front();
        if (rsp_valid) begin
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
          chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
          chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
        end
        mdone = (mdone + 1) % 65536;
      end
      if (eg >= 0) begin
        xs   = int'($signed(req_x[eg*W +: W]));
        ys   = int'($signed(req_y[eg*W +: W]));
        full = xs + ys + int'(req_cin[eg]);
        exp_q.push_back('{cyc + 2, eg, full[7:0], (full[7:0] == 8'd0), (full > 127 || full < -128)});
        max = req_x[eg*W +: W]; may = req_y[eg*W +: W]; mac = req_cin[eg];
        mptr = eg;
        grant_log.push_back(eg);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int i, input logic [7:0] x, input logic [7:0] y, input bit c);
    req_x[i*W +: W] = x;
    req_y[i*W +: W] = y;
    req_cin[i]      = c;
  endtask

  task automatic clear_logs();
    rsp_log.delete();
    grant_log.delete();
  endtask

  task automatic chk_rsp(input string name, input int n, input int id, input logic [7:0] sum, input bit z, input bit o);
    if (rsp_log.size() > n) begin
      chk({name, "_id"}, 32'(rsp_log[n].id), 32'(id));
      chk({name, "_sum"}, 32'(rsp_log[n].sum), 32'(sum));
      chk({name, "_zero"}, 32'(rsp_log[n].zero), 32'(z));
      chk({name, "_ovf"}, 32'(rsp_log[n].ovf), 32'(o));
    end else begin
      chk({name, "_present"}, 32'(rsp_log.size()), 32'(n + 1));
    end
  endtask

  initial begin
    int fair_g[8];
    int mask_g[6];
    fair_g = '{0, 1, 2, 3, 0, 1, 2, 3};
    mask_g = '{1, 3, 1, 1, 1, 1};
    rst_n = 1'b0; req = '0; req_mask = '1; req_x = '0; req_y = '0; req_cin = '0;
    repeat (3) cycle();
    rst_n = 1'b1;

    // Single op from requester 0.
    clear_logs();
    set_op(0, 8'h11, 8'h22, 1'b1);
    req = 4'b0001;
    cycle();
    req = '0;
    repeat (4) cycle();
    chk("single_count", 32'(rsp_log.size()), 32'd1);
    chk_rsp("single", 0, 0, 8'h34, 1'b0, 1'b0);
    chk("single_done", 32'(done_cnt), 32'd1);

    // Zero and overflow cases from requester 2.
    clear_logs();
    req = 4'b0100;
    set_op(2, 8'h01, 8'hFF, 1'b0); cycle();
    set_op(2, 8'd100, 8'd100, 1'b0); cycle();
    set_op(2, 8'h80, 8'hFF, 1'b0); cycle();
    req = '0;
    repeat (4) cycle();
    chk("zo_count", 32'(rsp_log.size()), 32'd3);
    chk_rsp("zo0", 0, 2, 8'h00, 1'b1, 1'b0);
    chk_rsp("zo1", 1, 2, 8'hC8, 1'b0, 1'b1);
    chk_rsp("zo2", 2, 2, 8'h7F, 1'b0, 1'b1);
    chk("zo_done", 32'(done_cnt), 32'd4);

    // Idle: nothing granted, operands hold.
    clear_logs();
    repeat (10) cycle();
    chk("idle_grants", 32'(grant_log.size()), 32'd0);
    chk("idle_rsps", 32'(rsp_log.size()), 32'd0);
    chk("idle_add_x", 32'(add_x), 32'h80);
    chk("idle_add_y", 32'(add_y), 32'hFF);
    chk("idle_done", 32'(done_cnt), 32'd4);

    // Fairness with all four requesting.
    pulse_reset();
    clear_logs();
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i * 16 + 1), 8'd3, i[0]);
    req = 4'b1111;
    repeat (8) cycle();
    req = '0;
    repeat (4) cycle();
    chk("fair_grants", 32'(grant_log.size()), 32'd8);
    chk("fair_rsps", 32'(rsp_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (grant_log.size() > i) chk("fair_gnt_id", 32'(grant_log[i]), 32'(fair_g[i]));
      if (rsp_log.size() > i) chk("fair_rsp_id", 32'(rsp_log[i].id), 32'(fair_g[i]));
    end

    // Masking, then dropping requester 3 mid-stream.
    pulse_reset();
    clear_logs();
    req_mask = 4'b1010;
    req = 4'b1111;
    repeat (3) cycle();
    req_mask = 4'b0010;
    repeat (3) cycle();
    req = '0;
    req_mask = '1;
    repeat (4) cycle();
    chk("mask_grants", 32'(grant_log.size()), 32'd6);
    chk("mask_rsps", 32'(rsp_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (grant_log.size() > i) chk("mask_gnt_id", 32'(grant_log[i]), 32'(mask_g[i]));
      if (rsp_log.size() > i) chk("mask_rsp_id", 32'(rsp_log[i].id), 32'(mask_g[i]));
    end

    // Reset with two operations in flight.
    pulse_reset();
    clear_logs();
    req = 4'b0011;
    cycle();
    cycle();
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("mid_grants", 32'(grant_log.size()), 32'd2);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_add_x", 32'(add_x), 32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    repeat (5) cycle();
    chk("mid_no_rsp", 32'(rsp_log.size()), 32'd0);
    chk("mid_done", 32'(done_cnt), 32'd0);
    req = 4'b1111;
    #1;
    chk("mid_first_gnt", 32'(gnt), 32'd1);
    cycle();
    req = '0;
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
